// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency BRAM between NUM_REQ requesters.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_we,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   lock_owner_q, lock_owner_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [PTR_W-1:0]   search_base;
    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_idx;
    int                 idx;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    assign search_base = rr_ptr_q;
`endif

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    // Grant selection: the lock owner only while locked, otherwise the first valid from search_base.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (state_q == ST_LOCKED) begin
            gnt_vld = req_valid[lock_owner_q];
            gnt_idx = lock_owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(search_base) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_vld && req_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
        end
        // Nothing is granted while reset is held, so the memory sees no traffic.
        if (!rst_n) gnt_vld = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            mem_we    = req_write[gnt_idx];
            mem_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        rsp_valid_d  = '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (gnt_vld) begin
            if (!req_write[gnt_idx]) rsp_valid_d[gnt_idx] = 1'b1;
            if (req_lock[gnt_idx]) begin
                // Pointer is frozen while locked; it moves past the owner on unlock.
                state_d      = ST_LOCKED;
                lock_owner_d = gnt_idx;
            end else begin
                state_d = ST_ARB;
`ifndef BRAM_ARB_FIXED_PRIO_EN
                rr_ptr_d = wrap_inc(gnt_idx);
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            lock_owner_q <= '0;
            rsp_valid_q  <= '0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rsp_valid_q  <= rsp_valid_d;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter (NUM_REQ=2) with a behavioural BRAM and a response scoreboard.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_write, req_lock, req_ready, rsp_valid;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] rsp_data, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;

    typedef struct {
        logic [1:0]  who;
        logic [15:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] mem [256];

    bram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM: registered read, read-during-write returns old data.
    initial foreach (mem[i]) mem[i] = 16'h0000;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected rsp_valid", {30'd0, rsp_valid}, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.who});
                check("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] exp_rdy, input logic [15:0] exp_rd,
                         input bit push_rsp, input string name);
        logic [7:0]  ea;
        logic [15:0] ed;
        @(negedge clk);
        req_valid = v;
        req_write = w;
        req_lock  = l;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        ea = exp_rdy[1] ? a1 : (exp_rdy[0] ? a0 : 8'h00);
        ed = exp_rdy[1] ? d1 : (exp_rdy[0] ? d0 : 16'h0000);
        check({name, " req_ready"}, {30'd0, req_ready}, {30'd0, exp_rdy});
        check({name, " mem_we"}, {31'd0, mem_we}, {31'd0, |(exp_rdy & w)});
        check({name, " mem_addr"}, {24'd0, mem_addr}, {24'd0, ea});
        if (|(exp_rdy & w)) check({name, " mem_wdata"}, {16'd0, mem_wdata}, {16'd0, ed});
        if (push_rsp && exp_rdy != 2'b00 && !(|(exp_rdy & w)))
            exp_q.push_back('{who: exp_rdy, data: exp_rd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_lock  = 2'b00;
        req_addr  = 16'h0201;
        req_wdata = 32'h0;
        #2;
        check("reset req_ready", {30'd0, req_ready}, 32'd0);
        check("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", {24'd0, mem_addr}, 32'd0);
        check("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
        drive(2'b01, 2'b01, 2'b00, 8'h01, 8'h02, 16'h1111, 16'h0, 2'b01, 16'h0, 1, "fp wr01");
        for (int i = 0; i < 4; i++)
            drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "fp contend");
`else
        // Write then read-after-write on requester 0.
        drive(2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 16'hBEEF, 16'h0, 2'b01, 16'h0, 1, "wr 10");
        drive(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0, 16'h0, 2'b01, 16'hBEEF, 1, "rd 10");
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0, 1, "idle");
        // Preload; pointer ends at 0.
        drive(2'b01, 2'b01, 2'b00, 8'h01, 8'h00, 16'h1111, 16'h0, 2'b01, 16'h0, 1, "wr 01");
        drive(2'b01, 2'b01, 2'b00, 8'h20, 8'h00, 16'hABCD, 16'h0, 2'b01, 16'h0, 1, "wr 20");
        drive(2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 16'h0, 16'h2222, 2'b10, 16'h0, 1, "wr 02");
        // Both reading continuously: grants alternate.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "alt r0");
            drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 16'h2222, 1, "alt r1");
        end
        // Lock: req1 read-modify-write of 0x20 while req0 keeps asking.
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "pre lock");
        drive(2'b11, 2'b00, 2'b10, 8'h01, 8'h20, 16'h0, 16'h0, 2'b10, 16'hABCD, 1, "lock rd");
        drive(2'b11, 2'b10, 2'b00, 8'h01, 8'h20, 16'h0, 16'h5A5A, 2'b10, 16'h0, 1, "unlock wr");
        drive(2'b11, 2'b00, 2'b00, 8'h20, 8'h02, 16'h0, 16'h0, 2'b01, 16'h5A5A, 1, "post unlock");
        // Owner drops valid for 3 cycles while locked: req0 write is starved.
        drive(2'b11, 2'b00, 2'b10, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 16'h2222, 1, "lock2");
        for (int i = 0; i < 3; i++)
            drive(2'b01, 2'b01, 2'b10, 8'h01, 8'h02, 16'h7777, 16'h0, 2'b00, 16'h0, 1, "starve");
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 16'h2222, 1, "unlock2");
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "after starve");
        // Lock asserted without valid is ignored.
        drive(2'b10, 2'b00, 2'b01, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 16'h2222, 1, "bad lock");
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "bad lock rr");
        drive(2'b10, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b10, 16'h2222, 1, "to ptr0");
        // Reset right after a read grant: the response is dropped and the pointer restarts at 0.
        drive(2'b01, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h0, 0, "rd before rst");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("release rsp_valid", {30'd0, rsp_valid}, 32'd0);
        drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 2'b01, 16'h1111, 1, "post rst");
`endif
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0, 1, "drain");
        drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0, 1, "drain");
        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
